// File: rtl/fu_alloc_ctrl_pkg.sv
// Shared configuration, operation categories and FU pool helpers for fu_alloc_ctrl.
package fu_alloc_ctrl_pkg;

    localparam int unsigned N          = 3;
    localparam int unsigned NUM_ALU    = 2;
    localparam int unsigned NUM_MULT   = 1;
    localparam int unsigned NUM_BRANCH = 1;
    localparam int unsigned NUM_MEM    = 1;
    localparam int unsigned MULT_LAT   = 4;

    localparam int unsigned FU_MAX_AM = (NUM_ALU > NUM_MULT) ? NUM_ALU : NUM_MULT;
    localparam int unsigned FU_MAX_BM = (NUM_BRANCH > NUM_MEM) ? NUM_BRANCH : NUM_MEM;
    localparam int unsigned FU_MAX    = (FU_MAX_AM > FU_MAX_BM) ? FU_MAX_AM : FU_MAX_BM;
    localparam int unsigned IDX_W     = (FU_MAX > 1) ? $clog2(FU_MAX) : 1;

    typedef logic [IDX_W-1:0] FU_IDX;

    typedef enum logic [2:0] {
        CAT_ALU    = 3'd0,
        CAT_MULT   = 3'd1,
        CAT_BRANCH = 3'd2,
        CAT_MEM    = 3'd3,
        CAT_CSR    = 3'd4,
        CAT_NOP    = 3'd5
    } OP_CATEGORY;

    typedef enum logic [2:0] {
        POOL_NONE,
        POOL_ALU,
        POOL_MULT,
        POOL_BRANCH,
        POOL_MEM
    } fu_pool_e;

    typedef enum logic {
        OCC_IDLE,
        OCC_BUSY
    } occ_state_e;

    // CSR ops execute on the ALUs, so they share that pool.
    function automatic fu_pool_e cat_pool(input OP_CATEGORY cat);
        case (cat)
            CAT_ALU, CAT_CSR: return POOL_ALU;
            CAT_MULT:         return POOL_MULT;
            CAT_BRANCH:       return POOL_BRANCH;
            CAT_MEM:          return POOL_MEM;
            default:          return POOL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fu_alloc_ctrl_if.sv
// Issue-side bundle: issue slots and completions in, availability and bindings out.
interface fu_alloc_ctrl_if;
    import fu_alloc_ctrl_pkg::*;

    logic                    mispredict;
    logic [N-1:0]            issue_valid;
    OP_CATEGORY [N-1:0]      issue_cat;
    logic [NUM_MEM-1:0]      mem_done;

    logic [NUM_ALU-1:0]      alu_avail;
    logic [NUM_BRANCH-1:0]   branch_avail;
    logic [NUM_MULT-1:0]     mult_avail;
    logic [NUM_MEM-1:0]      mem_avail;
    logic [N-1:0]            fu_valid;
    FU_IDX [N-1:0]           fu_idx;
    logic [NUM_MULT-1:0]     mult_done;
    logic                    alloc_fault;

    modport master (
        output mispredict, issue_valid, issue_cat, mem_done,
        input  alu_avail, branch_avail, mult_avail, mem_avail,
        input  fu_valid, fu_idx, mult_done, alloc_fault
    );

    modport slave (
        input  mispredict, issue_valid, issue_cat, mem_done,
        output alu_avail, branch_avail, mult_avail, mem_avail,
        output fu_valid, fu_idx, mult_done, alloc_fault
    );

endinterface

// File: rtl/fu_occupancy.sv
// Busy tracker for one FU: fixed-latency countdown (FIXED_LAT>0) or done handshake (FIXED_LAT=0).
module fu_occupancy
    import fu_alloc_ctrl_pkg::*;
#(
    parameter int unsigned FIXED_LAT = 0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_bind,
    input  logic i_flush,
    input  logic i_done,
    output logic o_busy,
    output logic o_done,
    output logic o_spurious
);

    localparam int unsigned CNT_W    = (FIXED_LAT > 1) ? $clog2(FIXED_LAT + 1) : 1;
    localparam int unsigned LOAD     = (FIXED_LAT > 0) ? FIXED_LAT - 1 : 0;
    localparam logic        IS_FIXED = (FIXED_LAT != 0);

    occ_state_e       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= OCC_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        o_done    = 1'b0;
        unique case (r_state)
            OCC_IDLE: begin
                if (i_bind) begin
                    w_state_d = OCC_BUSY;
                    w_cnt_d   = CNT_W'(LOAD);
                end
            end
            OCC_BUSY: begin
                if (IS_FIXED) begin
                    // A flush discards the in-flight result, so no completion pulse.
                    if (i_flush) begin
                        w_state_d = OCC_IDLE;
                    end else if (r_cnt == '0) begin
                        o_done    = 1'b1;
                        w_state_d = OCC_IDLE;
                    end else begin
                        w_cnt_d = r_cnt - 1'b1;
                    end
                end else if (i_done) begin
                    w_state_d = OCC_IDLE;
                end
            end
            default: w_state_d = OCC_IDLE;
        endcase
    end

    assign o_busy     = (r_state == OCC_BUSY);
    assign o_spurious = i_done & (r_state == OCC_IDLE);

endmodule

// File: rtl/fu_alloc_ctrl.sv
// FU allocation controller: slot-ordered binder over per-category availability,
// with occupancy tracking for multipliers and memory units.
module fu_alloc_ctrl
    import fu_alloc_ctrl_pkg::*;
(
    input  logic            i_clock,
    input  logic            i_reset,
    fu_alloc_ctrl_if.slave  bus
);

    logic                  r_live;
    logic                  r_fault;
    logic [NUM_ALU-1:0]    w_alu_free;
    logic [NUM_BRANCH-1:0] w_br_free;
    logic [NUM_MULT-1:0]   w_mult_free, w_mult_bind, w_mult_busy, w_mult_spur;
    logic [NUM_MEM-1:0]    w_mem_free, w_mem_bind, w_mem_busy, w_mem_spur, w_unused_mem_fin;
    logic                  w_hit, w_miss;
    fu_pool_e              w_pool;

    // r_live keeps every avail vector flop-derived and low throughout reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_live  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_fault <= r_fault | w_miss | (|w_mult_spur) | (|w_mem_spur);
        end
    end

    assign bus.alu_avail    = {NUM_ALU{r_live}};
    assign bus.branch_avail = {NUM_BRANCH{r_live}};
    assign bus.mult_avail   = {NUM_MULT{r_live}} & ~w_mult_busy;
    assign bus.mem_avail    = {NUM_MEM{r_live}} & ~w_mem_busy;
    assign bus.alloc_fault  = r_fault;

    always_comb begin
        w_alu_free   = bus.alu_avail;
        w_br_free    = bus.branch_avail;
        w_mult_free  = bus.mult_avail;
        w_mem_free   = bus.mem_avail;
        bus.fu_valid = '0;
        bus.fu_idx   = '0;
        w_miss       = 1'b0;
        w_hit        = 1'b0;
        w_pool       = POOL_NONE;
        for (int s = 0; s < N; s++) begin
            w_hit  = 1'b0;
            w_pool = (bus.issue_valid[s] && !bus.mispredict) ? cat_pool(bus.issue_cat[s])
                                                             : POOL_NONE;
            unique case (w_pool)
                POOL_ALU: for (int u = 0; u < NUM_ALU; u++) begin
                    if (!w_hit && w_alu_free[u]) begin
                        w_hit = 1'b1; bus.fu_idx[s] = FU_IDX'(u); w_alu_free[u] = 1'b0;
                    end
                end
                POOL_BRANCH: for (int u = 0; u < NUM_BRANCH; u++) begin
                    if (!w_hit && w_br_free[u]) begin
                        w_hit = 1'b1; bus.fu_idx[s] = FU_IDX'(u); w_br_free[u] = 1'b0;
                    end
                end
                POOL_MULT: for (int u = 0; u < NUM_MULT; u++) begin
                    if (!w_hit && w_mult_free[u]) begin
                        w_hit = 1'b1; bus.fu_idx[s] = FU_IDX'(u); w_mult_free[u] = 1'b0;
                    end
                end
                POOL_MEM: for (int u = 0; u < NUM_MEM; u++) begin
                    if (!w_hit && w_mem_free[u]) begin
                        w_hit = 1'b1; bus.fu_idx[s] = FU_IDX'(u); w_mem_free[u] = 1'b0;
                    end
                end
                default: ;
            endcase
            bus.fu_valid[s] = w_hit;
            if (w_pool != POOL_NONE && !w_hit) w_miss = 1'b1;
        end
    end

    // Units taken this cycle are exactly those whose free bit the binder cleared.
    assign w_mult_bind = bus.mult_avail & ~w_mult_free;
    assign w_mem_bind  = bus.mem_avail & ~w_mem_free;

    for (genvar j = 0; j < NUM_MULT; j++) begin : g_mult
        fu_occupancy #(.FIXED_LAT(MULT_LAT)) u_occ (
            .i_clock    (i_clock),
            .i_reset    (i_reset),
            .i_bind     (w_mult_bind[j]),
            .i_flush    (bus.mispredict),
            .i_done     (1'b0),
            .o_busy     (w_mult_busy[j]),
            .o_done     (bus.mult_done[j]),
            .o_spurious (w_mult_spur[j])
        );
    end

    for (genvar j = 0; j < NUM_MEM; j++) begin : g_mem
        fu_occupancy #(.FIXED_LAT(0)) u_occ (
            .i_clock    (i_clock),
            .i_reset    (i_reset),
            .i_bind     (w_mem_bind[j]),
            .i_flush    (bus.mispredict),
            .i_done     (bus.mem_done[j]),
            .o_busy     (w_mem_busy[j]),
            .o_done     (w_unused_mem_fin[j]),
            .o_spurious (w_mem_spur[j])
        );
    end

endmodule

// File: tb/tb_fu_alloc_ctrl.sv
// Directed bench for fu_alloc_ctrl: cycle-level occupancy model plus literal spot checks.
module tb_fu_alloc_ctrl;
    import fu_alloc_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    fu_alloc_ctrl_if bus ();

    fu_alloc_ctrl dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: a multiplier is busy up to and including cycle m_until[j].
    bit m_live, n_live, m_fault, n_fault;
    int m_cyc, n_cyc;
    int m_until [NUM_MULT];
    int n_until [NUM_MULT];
    bit m_busy  [NUM_MEM];
    bit n_busy  [NUM_MEM];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live  <= 1'b0;
            m_fault <= 1'b0;
            m_cyc   <= 0;
            for (int j = 0; j < NUM_MULT; j++) m_until[j] <= -1;
            for (int j = 0; j < NUM_MEM; j++) m_busy[j] <= 1'b0;
        end else begin
            m_live  <= n_live;
            m_fault <= n_fault;
            m_cyc   <= n_cyc;
            m_until <= n_until;
            m_busy  <= n_busy;
        end
    end

    always @(negedge clk) begin
        logic [NUM_ALU-1:0]    e_alu, fa;
        logic [NUM_BRANCH-1:0] e_br, fb;
        logic [NUM_MULT-1:0]   e_mult, fm, e_done;
        logic [NUM_MEM-1:0]    e_mem, fe;
        logic [N-1:0]          ev;
        int                    ei [N];
        bit                    known;
        if (!rst_n) begin
            check("rst_alu_avail", 32'(bus.alu_avail), 32'd0);
            check("rst_branch_avail", 32'(bus.branch_avail), 32'd0);
            check("rst_mult_avail", 32'(bus.mult_avail), 32'd0);
            check("rst_mem_avail", 32'(bus.mem_avail), 32'd0);
            check("rst_fu_valid", 32'(bus.fu_valid), 32'd0);
            check("rst_mult_done", 32'(bus.mult_done), 32'd0);
            check("rst_fault", 32'(bus.alloc_fault), 32'd0);
            n_live = 1'b1; n_fault = 1'b0; n_cyc = 0;
            for (int j = 0; j < NUM_MULT; j++) n_until[j] = -1;
            for (int j = 0; j < NUM_MEM; j++) n_busy[j] = 1'b0;
        end else begin
            e_alu = m_live ? '1 : '0;
            e_br  = m_live ? '1 : '0;
            for (int j = 0; j < NUM_MULT; j++) begin
                e_mult[j] = m_live && (m_cyc > m_until[j]);
                e_done[j] = (m_until[j] == m_cyc) && !bus.mispredict;
            end
            for (int j = 0; j < NUM_MEM; j++) e_mem[j] = m_live && !m_busy[j];
            fa = e_alu; fb = e_br; fm = e_mult; fe = e_mem;
            n_live = 1'b1; n_fault = m_fault; n_cyc = m_cyc + 1;
            n_until = m_until; n_busy = m_busy;
            for (int s = 0; s < N; s++) begin
                ev[s] = 1'b0; ei[s] = 0; known = 1'b1;
                if (bus.issue_valid[s] && !bus.mispredict) begin
                    case (bus.issue_cat[s])
                        CAT_ALU, CAT_CSR: for (int u = 0; u < NUM_ALU; u++)
                            if (!ev[s] && fa[u]) begin ev[s] = 1'b1; ei[s] = u; fa[u] = 1'b0; end
                        CAT_BRANCH: for (int u = 0; u < NUM_BRANCH; u++)
                            if (!ev[s] && fb[u]) begin ev[s] = 1'b1; ei[s] = u; fb[u] = 1'b0; end
                        CAT_MULT: for (int u = 0; u < NUM_MULT; u++)
                            if (!ev[s] && fm[u]) begin
                                ev[s] = 1'b1; ei[s] = u; fm[u] = 1'b0;
                                n_until[u] = m_cyc + int'(MULT_LAT);
                            end
                        CAT_MEM: for (int u = 0; u < NUM_MEM; u++)
                            if (!ev[s] && fe[u]) begin
                                ev[s] = 1'b1; ei[s] = u; fe[u] = 1'b0; n_busy[u] = 1'b1;
                            end
                        default: known = 1'b0;
                    endcase
                    if (known && !ev[s]) n_fault = 1'b1;
                end
            end
            if (bus.mispredict)
                for (int j = 0; j < NUM_MULT; j++)
                    if (m_cyc <= m_until[j]) n_until[j] = -1;
            for (int j = 0; j < NUM_MEM; j++)
                if (bus.mem_done[j]) begin
                    if (m_busy[j]) n_busy[j] = 1'b0;
                    else n_fault = 1'b1;
                end
            check("alu_avail", 32'(bus.alu_avail), 32'(e_alu));
            check("branch_avail", 32'(bus.branch_avail), 32'(e_br));
            check("mult_avail", 32'(bus.mult_avail), 32'(e_mult));
            check("mem_avail", 32'(bus.mem_avail), 32'(e_mem));
            check("fu_valid", 32'(bus.fu_valid), 32'(ev));
            for (int s = 0; s < N; s++)
                if (ev[s]) check($sformatf("fu_idx[%0d]", s), 32'(bus.fu_idx[s]), 32'(ei[s]));
            check("mult_done", 32'(bus.mult_done), 32'(e_done));
            check("alloc_fault", 32'(bus.alloc_fault), 32'(m_fault));
        end
    end

    task automatic idle();
        bus.issue_valid = '0;
        bus.mispredict  = 1'b0;
        bus.mem_done    = '0;
        for (int s = 0; s < N; s++) bus.issue_cat[s] = CAT_NOP;
    endtask

    task automatic issue(input logic [N-1:0] v, input OP_CATEGORY c0, input OP_CATEGORY c1,
                         input OP_CATEGORY c2, input logic mp);
        idle();
        bus.issue_valid  = v;
        bus.issue_cat[0] = c0;
        bus.issue_cat[1] = c1;
        bus.issue_cat[2] = c2;
        bus.mispredict   = mp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release just before an edge so the first sampled cycle is already live.
    task automatic release_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle();
        repeat (3) tick();
        @(negedge clk);
        check("lit_rst_mult_avail", 32'(bus.mult_avail), 32'd0);
        release_reset();

        // Two ALUs and a multiplier in the first live cycle.
        check("lit_live_alu_avail", 32'(bus.alu_avail), 32'h3);
        issue(3'b111, CAT_ALU, CAT_ALU, CAT_MULT, 1'b0);
        @(negedge clk);
        check("lit_a_fu_valid", 32'(bus.fu_valid), 32'h7);
        check("lit_a_idx0", 32'(bus.fu_idx[0]), 32'd0);
        check("lit_a_idx1", 32'(bus.fu_idx[1]), 32'd1);
        check("lit_a_idx2", 32'(bus.fu_idx[2]), 32'd0);
        tick();
        idle();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("lit_a_mult_avail_c%0d", c), 32'(bus.mult_avail), (c == 5) ? 32'd1 : 32'd0);
            check($sformatf("lit_a_mult_done_c%0d", c), 32'(bus.mult_done), (c == 4) ? 32'd1 : 32'd0);
            tick();
        end

        // Memory + multiplier bind, then a flush two cycles later.
        issue(3'b111, CAT_MEM, CAT_MULT, CAT_CSR, 1'b0);
        @(negedge clk);
        check("lit_b_fu_valid", 32'(bus.fu_valid), 32'h7);
        check("lit_b_idx2", 32'(bus.fu_idx[2]), 32'd0);
        tick();
        idle();
        tick();
        issue(3'b111, CAT_ALU, CAT_BRANCH, CAT_ALU, 1'b1);
        @(negedge clk);
        check("lit_b_mp_fu_valid", 32'(bus.fu_valid), 32'd0);
        check("lit_b_mp_mult_avail", 32'(bus.mult_avail), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("lit_b_flushed_mult_avail", 32'(bus.mult_avail), 32'd1);
        check("lit_b_mem_still_busy", 32'(bus.mem_avail), 32'd0);
        tick();
        tick();
        bus.mem_done = 1'b1;
        @(negedge clk);
        check("lit_b_mem_done_cycle", 32'(bus.mem_avail), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("lit_b_mem_freed", 32'(bus.mem_avail), 32'd1);
        check("lit_b_no_fault", 32'(bus.alloc_fault), 32'd0);
        tick();

        // Mixed pools, and an unrecognised category that must neither bind nor fault.
        issue(3'b111, CAT_BRANCH, CAT_CSR, CAT_ALU, 1'b0);
        @(negedge clk);
        check("lit_c_idx2", 32'(bus.fu_idx[2]), 32'd1);
        tick();
        issue(3'b111, CAT_ALU, CAT_NOP, CAT_BRANCH, 1'b0);
        @(negedge clk);
        check("lit_c_fu_valid", 32'(bus.fu_valid), 32'h5);
        tick();

        // Multiplier oversubscription sets the sticky fault.
        issue(3'b111, CAT_MULT, CAT_MULT, CAT_ALU, 1'b0);
        @(negedge clk);
        check("lit_d_fu_valid", 32'(bus.fu_valid), 32'h5);
        check("lit_d_fault_before", 32'(bus.alloc_fault), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("lit_d_fault_set", 32'(bus.alloc_fault), 32'd1);
        tick();
        @(negedge clk);
        check("lit_d_fault_sticky", 32'(bus.alloc_fault), 32'd1);
        tick();

        // Reset in the third busy cycle of that multiply.
        rst_n = 1'b0;
        @(negedge clk);
        check("lit_e_rst_mult_avail", 32'(bus.mult_avail), 32'd0);
        check("lit_e_rst_fault", 32'(bus.alloc_fault), 32'd0);
        tick();
        release_reset();
        @(negedge clk);
        check("lit_e_live_mult_avail", 32'(bus.mult_avail), 32'd1);
        check("lit_e_live_mem_avail", 32'(bus.mem_avail), 32'd1);
        repeat (4) tick();

        // Completion on an idle memory unit is a fault.
        bus.mem_done = 1'b1;
        @(negedge clk);
        check("lit_f_fault_before", 32'(bus.alloc_fault), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("lit_f_fault_set", 32'(bus.alloc_fault), 32'd1);
        tick();

        // ALU pool exhaustion after a clean reset.
        rst_n = 1'b0;
        tick();
        release_reset();
        issue(3'b111, CAT_ALU, CAT_CSR, CAT_ALU, 1'b0);
        @(negedge clk);
        check("lit_g_fu_valid", 32'(bus.fu_valid), 32'h3);
        tick();
        idle();
        @(negedge clk);
        check("lit_g_fault_set", 32'(bus.alloc_fault), 32'd1);
        repeat (2) tick();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
